// File: rtl/ext_pipe_if.sv
// Producer/consumer handshake bundle for the immediate-extension buffer.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface ext_pipe_if #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/ext_pipe.sv
// Immediate extender feeding a small FIFO: values are widened at push time
// (sign, zero, upper, branch-offset) and drained in strict order.
module ext_pipe #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2,
    parameter int SHAMT = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    ext_pipe_if.slave                    bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int EXT_W = OUT_W - IN_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } mode_e;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm, input mode_e mode);
        logic [OUT_W-1:0] sext;
        sext = {{EXT_W{imm[IN_W-1]}}, imm};
        case (mode)
            MODE_SIGN:   extend = sext;
            MODE_ZERO:   extend = {{EXT_W{1'b0}}, imm};
            MODE_UPPER:  extend = {imm, {EXT_W{1'b0}}};
            MODE_BRANCH: extend = sext << SHAMT;
            default:     extend = sext;
        endcase
    endfunction

    // Explicit wrap so non-power-of-two depths never index past the last entry.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus.in_ready  = (count != CNT_W'(DEPTH));
    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; validity is tracked by count alone and
    // out_data is masked while empty, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[wr_ptr] <= extend(bus.in_imm, mode_e'(bus.in_mode));
        end
    end
endmodule
